cv32e40p_sleep_ctrl: RTL and testbench

Free-running-clock controller that decides when the core clock may be stopped. Its clock_en_o drives the en_i input of the core clock gate directly.
It tracks outstanding OBI instruction and data transactions, drains them after a sleep request, and gates the clock off. It re-enables the clock on an interrupt or debug wake event.
It also provides a sleep-cycle performance counter and a sticky bus-accounting error flag.

---
 rtl/cv32e40p_sleep_ctrl_if.sv | 24 ++
 rtl/cv32e40p_sleep_ctrl.sv | 122 ++++++++++++
 tb/tb_cv32e40p_sleep_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_sleep_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cv32e40p_sleep_ctrl_if : OBI instr/data handshake observed by sleep ctrl |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface cv32e40p_sleep_ctrl_if;
  logic instr_req_i;
  logic instr_gnt_i;
  logic instr_rvalid_i;
  logic data_req_i;
  logic data_gnt_i;
  logic data_rvalid_i;

  modport master (
    output instr_req_i, instr_gnt_i, instr_rvalid_i,
    output data_req_i,  data_gnt_i,  data_rvalid_i
  );

  modport slave (
    input instr_req_i, instr_gnt_i, instr_rvalid_i,
    input data_req_i,  data_gnt_i,  data_rvalid_i
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_sleep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cv32e40p_sleep_ctrl : drains OBI traffic and gates the core clock      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module cv32e40p_sleep_ctrl #(
  parameter int CNT_W       = 2,
  parameter int SLEEP_CNT_W = 32
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  cv32e40p_sleep_ctrl_if.slave        obi,
  input  wire logic                   fetch_enable_i,
  input  wire logic                   sleep_req_i,
  input  wire logic                   irq_pending_i,
  input  wire logic                   debug_req_i,
  input  wire logic                   cnt_clr_i,
  output logic                        clock_en_o,
  output logic                        core_sleep_o,
  output logic                        busy_o,
  output logic [SLEEP_CNT_W-1:0]      sleep_cycles_o,
  output logic                        err_o
);

  localparam logic [CNT_W-1:0]       C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]       C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SLEEP_CNT_W-1:0] C_SLP_ONE = {{(SLEEP_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SLEEP = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_clock_en;
  logic [CNT_W-1:0]       r_instr_cnt;
  logic [CNT_W-1:0]       r_data_cnt;
  logic [SLEEP_CNT_W-1:0] r_sleep_cnt;
  logic                   r_err;

  logic                   w_wake;
  logic                   w_drained;
  logic [CNT_W:0]         w_instr_upd;
  logic [CNT_W:0]         w_data_upd;

  // Returns {error, next_count}; on over/underflow the count holds.
  function automatic logic [CNT_W:0] f_cnt_upd(input logic [CNT_W-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == C_CNT_MAX) res[CNT_W] = 1'b1;
      else                  res[CNT_W-1:0] = cnt + C_CNT_ONE;
    end else if (dec && !inc) begin
      if (cnt == '0) res[CNT_W] = 1'b1;
      else           res[CNT_W-1:0] = cnt - C_CNT_ONE;
    end
    return res;
  endfunction

  assign w_wake      = irq_pending_i | debug_req_i;
  assign w_drained   = (r_instr_cnt == '0) && (r_data_cnt == '0) &&
                       !obi.instr_req_i && !obi.data_req_i;
  assign w_instr_upd = f_cnt_upd(r_instr_cnt, obi.instr_req_i & obi.instr_gnt_i,
                                 obi.instr_rvalid_i);
  assign w_data_upd  = f_cnt_upd(r_data_cnt, obi.data_req_i & obi.data_gnt_i,
                                 obi.data_rvalid_i);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:   if (fetch_enable_i) w_state_nxt = ST_RUN;
      ST_RUN:   if (sleep_req_i && !w_wake) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_wake || !sleep_req_i) w_state_nxt = ST_RUN;
        else if (w_drained)         w_state_nxt = ST_SLEEP;
      end
      ST_SLEEP: if (w_wake) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_OFF;
    endcase
  end

  // The clock enable gets its own flop so the gate sees a clean registered signal.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_OFF;
      r_clock_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clock_en <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_cnt <= '0;
      r_data_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_instr_cnt <= w_instr_upd[CNT_W-1:0];
      r_data_cnt  <= w_data_upd[CNT_W-1:0];
      if (w_instr_upd[CNT_W] || w_data_upd[CNT_W]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    r_sleep_cnt <= '0;
    else if (cnt_clr_i)           r_sleep_cnt <= '0;
    else if (r_state == ST_SLEEP) r_sleep_cnt <= r_sleep_cnt + C_SLP_ONE;
  end

  assign clock_en_o     = r_clock_en;
  assign core_sleep_o   = (r_state == ST_SLEEP);
  assign busy_o         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign sleep_cycles_o = r_sleep_cnt;
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_sleep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cv32e40p_sleep_ctrl : randomized bench with behavioural model       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_cv32e40p_sleep_ctrl;
  localparam int CW   = 2;
  localparam int SCW  = 4;
  localparam int MAXO = (1 << CW) - 1;
  localparam int MD_OFF = 0, MD_RUN = 1, MD_DRAIN = 2, MD_SLEEP = 3;

  logic clk = 1'b0;
  logic rst, fetch_enable, sleep_req, irq, dbg, cnt_clr;
  logic clock_en, core_sleep, busy, err;
  logic [SCW-1:0] sleep_cycles;

  cv32e40p_sleep_ctrl_if bus ();

  cv32e40p_sleep_ctrl #(.CNT_W(CW), .SLEEP_CNT_W(SCW)) dut (
    .clk_i(clk), .rst_i(rst), .obi(bus.slave),
    .fetch_enable_i(fetch_enable), .sleep_req_i(sleep_req),
    .irq_pending_i(irq), .debug_req_i(dbg), .cnt_clr_i(cnt_clr),
    .clock_en_o(clock_en), .core_sleep_o(core_sleep), .busy_o(busy),
    .sleep_cycles_o(sleep_cycles), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_mode, m_ic, m_dc, m_sc;
  bit m_err;

  function automatic bit exp_en();    return (m_mode == MD_RUN) || (m_mode == MD_DRAIN); endfunction
  function automatic bit exp_sleep(); return m_mode == MD_SLEEP; endfunction

  task automatic model_reset();
    m_mode = MD_OFF; m_ic = 0; m_dc = 0; m_sc = 0; m_err = 0;
  endtask

  task automatic track(inout int c, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (c == MAXO) m_err = 1; else c++;
    end else if (dec && !inc) begin
      if (c == 0) m_err = 1; else c--;
    end
  endtask

  // Advance one clock edge and update the reference model from the inputs seen there.
  task automatic step();
    bit wake, drained;
    int nm;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      wake    = irq | dbg;
      drained = (m_ic == 0) && (m_dc == 0) && !bus.instr_req_i && !bus.data_req_i;
      nm = m_mode;
      case (m_mode)
        MD_OFF:   if (fetch_enable) nm = MD_RUN;
        MD_RUN:   if (sleep_req && !wake) nm = MD_DRAIN;
        MD_DRAIN: if (wake || !sleep_req) nm = MD_RUN; else if (drained) nm = MD_SLEEP;
        default:  if (wake) nm = MD_RUN;
      endcase
      if (cnt_clr) m_sc = 0;
      else if (m_mode == MD_SLEEP) m_sc = (m_sc + 1) % (1 << SCW);
      track(m_ic, bus.instr_req_i & bus.instr_gnt_i, bus.instr_rvalid_i);
      track(m_dc, bus.data_req_i & bus.data_gnt_i, bus.data_rvalid_i);
      m_mode = nm;
    end
    #1;
  endtask

  task automatic set_bus(input bit ir, ig, iv, dr, dg, dv);
    bus.instr_req_i = ir; bus.instr_gnt_i = ig; bus.instr_rvalid_i = iv;
    bus.data_req_i  = dr; bus.data_gnt_i  = dg; bus.data_rvalid_i  = dv;
  endtask

  task automatic idle_inputs();
    fetch_enable = 0; sleep_req = 0; irq = 0; dbg = 0; cnt_clr = 0;
    set_bus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    step();
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (clock_en !== 1'b0)   begin errors++; $display("FAIL reset_clock_en: got %b expected 0", clock_en); end
    checks++; if (core_sleep !== 1'b0) begin errors++; $display("FAIL reset_core_sleep: got %b expected 0", core_sleep); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sleep_cycles !== '0) begin errors++; $display("FAIL reset_sleep_cycles: got %0d expected 0", sleep_cycles); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 0;
  endtask

  task automatic test_startup();
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL startup_off cycle %0d: got %b expected 0", c, clock_en); end
    end
    fetch_enable = 1;
    step();
    fetch_enable = 0;
    checks++; if (clock_en !== 1'b1) begin errors++; $display("FAIL startup_en: got %b expected 1", clock_en); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL startup_busy: got %b expected 1", busy); end
    checks++; if (sleep_cycles !== '0) begin errors++; $display("FAIL startup_sc: got %0d expected 0", sleep_cycles); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startup_stay_run: got %b expected 1", busy); end
  endtask

  task automatic test_sleep_wake();
    int low = 0;
    sleep_req = 1;
    for (int k = 1; k <= 7; k++) begin
      irq = (k == 7);
      step();
      if (!clock_en) low++;
      checks++; if (clock_en !== exp_en() || core_sleep !== exp_sleep()) begin
        errors++; $display("FAIL sleep_wake edge %0d: en=%b sleep=%b expected en=%b sleep=%b", k, clock_en, core_sleep, exp_en(), exp_sleep());
      end
    end
    checks++; if (low != 5) begin errors++; $display("FAIL sleep_low_cycles: got %0d expected 5", low); end
    checks++; if (sleep_cycles !== 4'd5) begin errors++; $display("FAIL sleep_cycles_count: got %0d expected 5", sleep_cycles); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wake_run: got %b expected 1", busy); end
    sleep_req = 0; irq = 0;
    step();
  endtask

  task automatic test_drain_traffic();
    set_bus(1, 1, 0, 0, 0, 0); step();
    set_bus(1, 1, 0, 1, 1, 0); step();
    set_bus(0, 0, 0, 0, 0, 0);
    sleep_req = 1;
    for (int k = 1; k <= 9; k++) begin
      set_bus(0, 0, (k == 3) || (k == 4), 0, 0, k == 6);
      step();
      checks++; if (clock_en !== ((k <= 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL drain_traffic edge %0d: en=%b expected %b", k, clock_en, (k <= 6));
      end
    end
    set_bus(0, 0, 0, 0, 0, 0);
    checks++; if (core_sleep !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL drain_sleep: sleep=%b err=%b expected sleep=1 err=0", core_sleep, err);
    end
    irq = 1; sleep_req = 0; step(); irq = 0; step();
  endtask

  task automatic test_abort();
    logic [SCW-1:0] sc0;
    set_bus(1, 1, 0, 0, 0, 0); step();
    set_bus(0, 0, 0, 0, 0, 0);
    sleep_req = 1; step();
    sc0 = SCW'(m_sc);
    checks++; if (busy !== 1'b1 || clock_en !== 1'b1) begin errors++; $display("FAIL abort_drain: busy=%b en=%b expected 1/1", busy, clock_en); end
    dbg = 1; step();
    checks++; if (clock_en !== 1'b1 || core_sleep !== 1'b0 || m_mode != MD_RUN) begin
      errors++; $display("FAIL abort_run: en=%b sleep=%b expected en=1 sleep=0", clock_en, core_sleep);
    end
    dbg = 0; sleep_req = 0;
    set_bus(0, 0, 1, 0, 0, 0); step();
    set_bus(0, 0, 0, 0, 0, 0); step();
    checks++; if (sleep_cycles !== sc0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_sc: sc=%0d err=%b expected sc=%0d err=0", sleep_cycles, err, sc0);
    end
  endtask

  task automatic test_counters();
    apply_reset(); rst = 0;
    set_bus(1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (err !== ((k == 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL cnt_overflow grant %0d: err=%b expected %b", k, err, k == 4); end
    end
    apply_reset(); rst = 0;
    set_bus(0, 0, 0, 0, 0, 1); step();
    set_bus(0, 0, 0, 0, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cnt_underflow: err=%b expected 1", err); end
    apply_reset(); rst = 0;
    set_bus(1, 1, 0, 0, 0, 0); step();
    set_bus(1, 1, 1, 0, 0, 0); step();
    set_bus(0, 0, 1, 0, 0, 0); step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cnt_inc_dec: err=%b expected 0", err); end
    step();
    set_bus(0, 0, 0, 0, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cnt_inc_dec_hold: err=%b expected 1", err); end
  endtask

  task automatic test_wrap_clear_reset();
    apply_reset(); rst = 0;
    fetch_enable = 1; step(); fetch_enable = 0;
    sleep_req = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (sleep_cycles !== SCW'(m_sc)) begin errors++; $display("FAIL wrap_count step %0d: got %0d expected %0d", k, sleep_cycles, m_sc); end
    end
    checks++; if (sleep_cycles !== 4'd2) begin errors++; $display("FAIL wrap_value: got %0d expected 2", sleep_cycles); end
    cnt_clr = 1; step(); cnt_clr = 0;
    checks++; if (sleep_cycles !== 4'd0) begin errors++; $display("FAIL clr_in_sleep: got %0d expected 0", sleep_cycles); end
    step();
    checks++; if (sleep_cycles !== 4'd1) begin errors++; $display("FAIL clr_resume: got %0d expected 1", sleep_cycles); end
    #2 rst = 1; model_reset();
    #1;
    checks++; if ({clock_en, core_sleep, busy, err} !== 4'b0 || sleep_cycles !== '0) begin
      errors++; $display("FAIL async_reset: en=%b sleep=%b busy=%b err=%b sc=%0d expected all 0", clock_en, core_sleep, busy, err, sleep_cycles);
    end
    step(); rst = 0; sleep_req = 0;
    step(); step();
    checks++; if (clock_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_stays_off: en=%b busy=%b expected 0/0", clock_en, busy); end
  endtask

  task automatic test_random();
    apply_reset(); rst = 0;
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 399) == 0);
      fetch_enable = ($urandom_range(0, 3) == 0);
      sleep_req    = ($urandom_range(0, 2) != 0);
      irq          = ($urandom_range(0, 9) == 0);
      dbg          = ($urandom_range(0, 19) == 0);
      cnt_clr      = ($urandom_range(0, 39) == 0);
      bus.instr_req_i    = ($urandom_range(0, 3) == 0);
      bus.instr_gnt_i    = $urandom_range(0, 1);
      bus.instr_rvalid_i = (m_ic > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      bus.data_req_i     = ($urandom_range(0, 3) == 0);
      bus.data_gnt_i     = $urandom_range(0, 1);
      bus.data_rvalid_i  = (m_dc > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (clock_en !== exp_en() || core_sleep !== exp_sleep() || busy !== exp_en() ||
          sleep_cycles !== SCW'(m_sc) || err !== m_err) begin
        errors++;
        $display("FAIL random cycle %0d: en=%b sleep=%b busy=%b sc=%0d err=%b expected en=%b sleep=%b busy=%b sc=%0d err=%b",
                 k, clock_en, core_sleep, busy, sleep_cycles, err, exp_en(), exp_sleep(), exp_en(), m_sc, m_err);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_startup();
    test_sleep_wake();
    test_drain_traffic();
    test_abort();
    test_counters();
    test_wrap_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
